// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer: op groups,
// arithmetic sub-ops, FSM state encoding and the effective-B helper.
package alu_seq_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] OPG_ARITH = 2'b00;
  localparam logic [1:0] OPG_LOGIC = 2'b01;
  localparam logic [1:0] OPG_SHR   = 2'b10;
  localparam logic [1:0] OPG_SHL   = 2'b11;

  localparam logic [1:0] AOP_PASS = 2'b00;
  localparam logic [1:0] AOP_ADD  = 2'b01;
  localparam logic [1:0] AOP_SUB  = 2'b10;
  localparam logic [1:0] AOP_DEC  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  // Second operand the ALU adds for each arithmetic sub-op.
  function automatic logic [DATA_W-1:0] opb_eff(input logic [1:0] sub,
                                                input logic [DATA_W-1:0] b);
    case (sub)
      AOP_PASS: return '0;
      AOP_ADD:  return b;
      AOP_SUB:  return ~b;
      default:  return '1;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_flags.sv
// Zero and signed-overflow flags for the value being captured.
// Overflow logic exists only when ALU_CMD_SEQ_OVF_EN is defined.
module alu_seq_flags
  import alu_seq_pkg::*;
(
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [3:0]        alu_s,
  input  logic [DATA_W-1:0] alu_f,
  input  logic [DATA_W-1:0] res,
  output logic              zero,
  output logic              ovf
);

  assign zero = (res == '0);

`ifdef ALU_CMD_SEQ_OVF_EN
  logic [DATA_W-1:0] opb;

  assign opb = opb_eff(alu_s[1:0], alu_b);
  assign ovf = (alu_s[3:2] == OPG_ARITH) &&
               (alu_a[DATA_W-1] == opb[DATA_W-1]) &&
               (alu_f[DATA_W-1] != alu_a[DATA_W-1]);
`else
  logic unused_ovf_in;

  assign unused_ovf_in = ^{alu_a, alu_b, alu_s, alu_f};
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Handshaked multi-cycle front end for the external combinational ALU;
// shifts run as repeated 1-bit passes. Optional overflow: ALU_CMD_SEQ_OVF_EN.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [31:0]        cmd_a,
  input  logic [31:0]        cmd_b,
  input  logic               cmd_cin,
  input  logic               cmd_dl,
  input  logic               cmd_dr,
  input  logic [SHAMT_W-1:0] cmd_shamt,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  output logic               alu_cin,
  output logic               alu_dl,
  output logic               alu_dr,
  output logic [3:0]         alu_s,
  input  logic [31:0]        alu_f,
  input  logic               alu_cout,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_f,
  output logic               rsp_cout,
  output logic               rsp_zero,
  output logic               rsp_ovf
);

  state_t             state, state_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0]         grp;
  logic               is_shift;
  logic               accept;
  logic               done;
  logic [31:0]        cap_f;
  logic               zero;
  logic               ovf;

  assign grp      = alu_s[3:2];
  assign is_shift = (grp == OPG_SHR) || (grp == OPG_SHL);
  assign accept   = cmd_valid && cmd_ready;
  // Shift-by-0 and the last shift pass both finish this cycle.
  assign done     = (state == EXEC) && (!is_shift || cnt <= SHAMT_W'(1));
  assign cap_f    = (is_shift && cnt == '0) ? alu_a : alu_f;

  alu_seq_flags u_flags (
    .alu_a (alu_a),
    .alu_b (alu_b),
    .alu_s (alu_s),
    .alu_f (alu_f),
    .res   (cap_f),
    .zero  (zero),
    .ovf   (ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = EXEC;
      EXEC:    if (done)      state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE) && !rst;
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_cin  <= 1'b0;
      alu_dl   <= 1'b0;
      alu_dr   <= 1'b0;
      alu_s    <= '0;
      cnt      <= '0;
      rsp_f    <= '0;
      rsp_cout <= 1'b0;
      rsp_zero <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            alu_cin <= cmd_cin;
            alu_dl  <= cmd_dl;
            alu_dr  <= cmd_dr;
            alu_s   <= cmd_op;
            cnt     <= cmd_shamt;
          end
        end
        EXEC: begin
          if (is_shift && cnt != '0) begin
            alu_a <= alu_f;
            cnt   <= cnt - SHAMT_W'(1);
          end
          if (done) begin
            rsp_f    <= cap_f;
            rsp_cout <= (grp == OPG_ARITH) && alu_cout;
            rsp_zero <= zero;
            rsp_ovf  <= ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU on the alu_* ports
// and a scoreboard of expected responses.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic        cmd_cin = 1'b0, cmd_dl = 1'b0, cmd_dr = 1'b0;
  logic [4:0]  cmd_shamt = '0;
  logic [31:0] alu_a, alu_b;
  logic        alu_cin, alu_dl, alu_dr;
  logic [3:0]  alu_s;
  logic [31:0] alu_f;
  logic        alu_cout;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_f;
  logic        rsp_cout, rsp_zero, rsp_ovf;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] f;
    logic        cout;
    logic        zero;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.SHAMT_W(5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_dl(cmd_dl),
    .cmd_dr(cmd_dr), .cmd_shamt(cmd_shamt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_dl(alu_dl),
    .alu_dr(alu_dr), .alu_s(alu_s), .alu_f(alu_f), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf)
  );

  // Behavioural stand-in for the team ALU: one combinational pass.
  logic [31:0] tb_opb;
  always_comb begin
    alu_f    = '0;
    alu_cout = 1'b0;
    tb_opb   = '0;
    case (alu_s[1:0])
      2'b00: tb_opb = '0;
      2'b01: tb_opb = alu_b;
      2'b10: tb_opb = ~alu_b;
      default: tb_opb = '1;
    endcase
    case (alu_s[3:2])
      2'b00: {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, tb_opb} + {32'b0, alu_cin};
      2'b01: begin
        case (alu_s[1:0])
          2'b00: alu_f = alu_a & alu_b;
          2'b01: alu_f = alu_a | alu_b;
          2'b10: alu_f = alu_a ^ alu_b;
          default: alu_f = ~alu_a;
        endcase
      end
      2'b10: alu_f = {alu_dr, alu_a[31:1]};
      default: alu_f = {alu_a[30:0], alu_dl};
    endcase
  end

  function automatic exp_t ref_model(input logic [3:0] op, input logic [31:0] a, b,
                                     input logic cin, dl, dr, input logic [4:0] shamt);
    exp_t e;
    logic [31:0] opb;
    logic [32:0] sum;
    longint      ssum;
    e.f = '0; e.cout = 1'b0; e.ovf = 1'b0; e.lat = 1;
    opb = (op[1:0] == 2'b00) ? 32'h0 : (op[1:0] == 2'b01) ? b :
          (op[1:0] == 2'b10) ? ~b : 32'hFFFF_FFFF;
    case (op[3:2])
      2'b00: begin
        sum    = {1'b0, a} + {1'b0, opb} + {32'b0, cin};
        e.f    = sum[31:0];
        e.cout = sum[32];
        ssum   = longint'($signed(a)) + longint'($signed(opb)) + longint'(cin);
`ifdef ALU_CMD_SEQ_OVF_EN
        e.ovf  = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
`endif
      end
      2'b01: begin
        case (op[1:0])
          2'b00: e.f = a & b;
          2'b01: e.f = a | b;
          2'b10: e.f = a ^ b;
          default: e.f = ~a;
        endcase
      end
      2'b10: begin
        e.f = a;
        for (int i = 0; i < int'(shamt); i++) e.f = {dr, e.f[31:1]};
        e.lat = (shamt == 0) ? 1 : int'(shamt);
      end
      default: begin
        e.f = a;
        for (int i = 0; i < int'(shamt); i++) e.f = {e.f[30:0], dl};
        e.lat = (shamt == 0) ? 1 : int'(shamt);
      end
    endcase
    e.zero = (e.f == 32'h0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command, wait for its response, optionally stall, then consume it.
  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [31:0] a, b,
                         input logic cin, dl, dr, input logic [4:0] shamt, input int hold);
    exp_t ep;
    int   lat;
    sb.push_back(ref_model(op, a, b, cin, dl, dr, shamt));
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin;
    cmd_dl = dl; cmd_dr = dr; cmd_shamt = shamt; cmd_valid = 1'b1;
    check({tag, ":cmd_ready"}, {63'b0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rsp_valid && lat < 100);
    ep = sb.pop_front();
    check({tag, ":latency"}, 64'(lat), 64'(ep.lat));
    check({tag, ":rsp_f"}, {32'b0, rsp_f}, {32'b0, ep.f});
    check({tag, ":rsp_cout"}, {63'b0, rsp_cout}, {63'b0, ep.cout});
    check({tag, ":rsp_zero"}, {63'b0, rsp_zero}, {63'b0, ep.zero});
    check({tag, ":rsp_ovf"}, {63'b0, rsp_ovf}, {63'b0, ep.ovf});
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, ":hold_valid"}, {63'b0, rsp_valid}, 64'd1);
      check({tag, ":hold_f"}, {32'b0, rsp_f}, {32'b0, ep.f});
      check({tag, ":hold_cmd_ready"}, {63'b0, cmd_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, ":post_valid"}, {63'b0, rsp_valid}, 64'd0);
    check({tag, ":post_cmd_ready"}, {63'b0, cmd_ready}, 64'd1);
  endtask

  initial begin
    logic [3:0] rop;
    #12;
    check("reset:cmd_ready", {63'b0, cmd_ready}, 64'd0);
    check("reset:outputs",
          64'({rsp_valid, rsp_f, rsp_cout, rsp_zero, rsp_ovf}), 64'd0);
    check("reset:alu", {alu_a, alu_b}, 64'd0);
    check("reset:alu_ctl", 64'({alu_cin, alu_dl, alu_dr, alu_s}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_cmd("add_wrap", 4'b0001, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 5'd0, 0);
    run_cmd("sub", 4'b0010, 32'd10, 32'd3, 1'b1, 1'b0, 1'b0, 5'd0, 0);
    run_cmd("shl4", 4'b1100, 32'h0000_000F, 32'h0, 1'b0, 1'b1, 1'b0, 5'd4, 0);
    run_cmd("shr0", 4'b1000, 32'h8000_0001, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 0);
    run_cmd("and_bp", 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0, 1'b0, 5'd0, 5);
    run_cmd("shr31", 4'b1000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 5'd31, 0);

    // Abort a long shift with reset in its third EXEC cycle.
    cmd_op = 4'b1100; cmd_a = 32'h1; cmd_shamt = 5'd31; cmd_dl = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("abort:outputs",
          64'({cmd_ready, rsp_valid, rsp_f, rsp_cout, rsp_zero, rsp_ovf}), 64'd0);
    check("abort:alu", {alu_a, alu_b}, 64'd0);
    check("abort:alu_ctl", 64'({alu_cin, alu_dl, alu_dr, alu_s}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort:no_rsp", {63'b0, rsp_valid}, 64'd0);
    end
    check("abort:cmd_ready", {63'b0, cmd_ready}, 64'd1);

    run_cmd("after_abort_shr3", 4'b1010, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 5'd3, 0);
    run_cmd("ovf_add", 4'b0001, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 5'd0, 0);
    run_cmd("or", 4'b0101, 32'h1234_0000, 32'h0000_5678, 1'b0, 1'b0, 1'b0, 5'd0, 1);
    run_cmd("dec_zero", 4'b0011, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 0);

    for (int i = 0; i < 6; i++) begin
      rop = 4'($urandom_range(0, 15));
      run_cmd("random", rop, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
              5'($urandom_range(0, 8)), int'($urandom_range(0, 2)));
    end

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-side initiator that drives the team's 32-bit combinational ALU and turns it into a handshaked, multi-cycle execution unit. It accepts one command per valid/ready transfer and presents operands and select code to the external ALU. Shift commands are iterated as repeated 1-bit ALU shifts, so a shift by N takes N passes. It then returns the captured result, carry and zero flag on a valid/ready response channel.

Parameters:
SHAMT_W, 5, width of the shift-amount field; supports shift counts 0..2^SHAMT_W-1.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  4  ALU select code; [3:2] group: 00 arith, 01 logic, 10 shift right, 11 shift left
cmd_a  input  32  operand A
cmd_b  input  32  operand B
cmd_cin  input  1  arithmetic carry-in
cmd_dl  input  1  left-shift fill bit
cmd_dr  input  1  right-shift fill bit
cmd_shamt  input  SHAMT_W  shift count; ignored for arith/logic
alu_a  output  32  to ALU operand A
alu_b  output  32  to ALU operand B
alu_cin  output  1  to ALU CIN
alu_dl  output  1  to ALU DL
alu_dr  output  1  to ALU DR
alu_s  output  4  to ALU select
alu_f  input  32  ALU result, combinational from alu_* outputs
alu_cout  input  1  ALU carry-out
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_f  output  32  result
rsp_cout  output  1  carry-out (0 for non-arith)
rsp_zero  output  1  rsp_f == 0
rsp_ovf  output  1  signed overflow (see Optional Feature)

Behaviour:
- Reset (async assert, sync to clk on release):
  - state = IDLE.
  - All outputs are 0, including cmd_ready, rsp_*, and all alu_* outputs.
  - Shift counter and working registers cleared.
- States: IDLE, EXEC, RESP (encoding from package). cmd_ready = 1 only in IDLE and not in reset.
- IDLE:
  - On cmd_valid && cmd_ready, register all cmd_* fields into alu_a/alu_b/alu_cin/alu_dl/alu_dr/alu_s.
  - Load cnt <= cmd_shamt and go to EXEC.
  - cmd_* fields are sampled only on the handshake.
- EXEC, arith/logic group: a single cycle.
  - At the next edge capture rsp_f <= alu_f.
  - Capture rsp_cout <= alu_cout for the arith group, 0 for logic.
  - Go to RESP.
- EXEC, shift group:
  - cnt == 0: rsp_f <= alu_a (unshifted), rsp_cout <= 0, go to RESP.
  - cnt >= 1, each cycle: alu_a <= alu_f and cnt <= cnt - 1.
  - When cnt == 1, also capture rsp_f <= alu_f and go to RESP.
  - The same DL/DR fill bit is shifted in on every pass.
- Latency from the accept edge to rsp_valid high:
  - 1 cycle for arith, logic and shift-by-0.
  - N cycles for a shift by N >= 1.
- RESP:
  - rsp_valid = 1; rsp_f, rsp_cout, rsp_zero and rsp_ovf are held stable while rsp_ready = 0.
  - On rsp_ready, go to IDLE; cmd_ready is high the following cycle.
  - No overlap between response and a new command.
- alu_* outputs hold their last values outside EXEC.
- rsp_zero is registered alongside rsp_f.
- Arithmetic wraps modulo 2^32; carry comes only via alu_cout.
- Reset mid-operation aborts the command: no response is produced, and the sequencer returns to IDLE after release.
- cmd_valid asserted in EXEC or RESP is ignored (cmd_ready = 0); the upstream holds the command.

Optional Feature:
ALU_CMD_SEQ_OVF_EN
- Defined: rsp_ovf is registered at capture for the arith group only.
  - Formula: (alu_a[31] == opb_eff[31]) && (alu_f[31] != alu_a[31]).
  - opb_eff is the effective second operand: 0, B, ~B or all-ones per alu_s[1:0].
  - rsp_ovf is 0 for all other groups.
- Undefined: rsp_ovf is tied to 0 and no overflow logic is synthesized.

Decomposition:
- Shared package alu_seq_pkg contains:
  - group constants OPG_ARITH=2'b00, OPG_LOGIC=2'b01, OPG_SHR=2'b10, OPG_SHL=2'b11;
  - arithmetic sub-op codes (00 pass, 01 add, 10 sub, 11 dec);
  - state encoding IDLE/EXEC/RESP;
  - data width constant 32.
- One natural sub-module: alu_seq_flags.
  - Combinational zero and overflow computation from alu_a, alu_s and alu_f.
  - Owns the ALU_CMD_SEQ_OVF_EN conditional.
- The ALU itself is instantiated outside this block; the bench connects the team's ALU to the alu_* ports.

Test Plan:
- ADD: op=0001, a=0xFFFFFFFF, b=0x1, cin=0 -> rsp_f=0x0, rsp_cout=1, rsp_zero=1; rsp_valid 1 cycle after accept.
- SUB: op=0010, a=10, b=3, cin=1 -> rsp_f=7, rsp_cout=1, rsp_zero=0.
- SHL: op=1100, shamt=4, a=0x0000000F, dl=1 -> rsp_f=0x000000FF; rsp_valid exactly 4 cycles after accept.
- SHR by 0: op=1000, shamt=0, a=0x80000001, dr=1 -> rsp_f=0x80000001, rsp_cout=0, latency 1.
- Backpressure: rsp_ready=0 for 5 cycles after an AND (a=0xF0F0F0F0, b=0xFF00FF00) -> rsp_f=0xF000F000 held stable, cmd_ready=0 throughout; cmd_ready=1 the cycle after the handshake.
- Reset mid-op and overflow:
  - SHL shamt=31 with rst pulsed at EXEC cycle 3 -> all outputs 0, no response; the next command completes normally.
  - With ALU_CMD_SEQ_OVF_EN: op=0001, a=0x7FFFFFFF, b=1 -> rsp_f=0x80000000, rsp_ovf=1.
